// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared FIFO geometry and Gray/binary pointer conversions
package sync_fifo_pkg;

    localparam int FIFO_ADDR_W = 3;
    localparam int FIFO_PTR_W  = FIFO_ADDR_W + 1;
    localparam int FIFO_DEPTH  = 8;

    function automatic logic [FIFO_PTR_W-1:0] bin2gray(input logic [FIFO_PTR_W-1:0] i_bin);
        return i_bin ^ (i_bin >> 1);
    endfunction

    function automatic logic [FIFO_PTR_W-1:0] gray2bin(input logic [FIFO_PTR_W-1:0] i_gray);
        logic [FIFO_PTR_W-1:0] w_bin;
        w_bin = '0;
        for (int i = 0; i < FIFO_PTR_W; i++) begin
            w_bin[i] = ^(i_gray >> i);
        end
        return w_bin;
    endfunction

endpackage

// File: rtl/sync_fifo_gray2bin.sv
// rtl/sync_fifo_gray2bin.sv - combinational Gray-to-binary converter, shared by both FIFO controllers
module sync_fifo_gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    // Each binary bit is the XOR of all Gray bits at or above its position.
    always_comb begin
        o_bin = '0;
        for (int i = 0; i < W; i++) begin
            o_bin[i] = ^(i_gray >> i);
        end
    end

endmodule

// File: rtl/sync_fifo_rd_ctrl.sv
// rtl/sync_fifo_rd_ctrl.sv - FIFO read-side pointer/flow controller; optional SYNC_FIFO_RD_OVF_CHECK_EN adds sticky ovf_err
module sync_fifo_rd_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W:0]   wr_ptr_gray_sync,
    output logic [ADDR_W:0]   rd_ptr_gray,
    output logic [ADDR_W-1:0] read_addr,
    output logic              read_enable,
    output logic              empty,
    output logic [ADDR_W:0]   fill_level,
    output logic              out_valid,
    input  logic              out_ready
`ifdef SYNC_FIFO_RD_OVF_CHECK_EN
    ,
    output logic              ovf_err
`endif
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;

    logic [PTR_W-1:0] r_rd_ptr_bin;
    logic [PTR_W-1:0] r_rd_ptr_gray;
    logic [PTR_W-1:0] r_fill_level;
    logic             r_out_valid;

    logic [PTR_W-1:0] w_wr_ptr_bin;
    logic [PTR_W-1:0] w_rd_ptr_bin_next;
    logic             w_empty;
    logic             w_fetch;

    sync_fifo_gray2bin #(.W(PTR_W)) u_wr_gray2bin (
        .i_gray (wr_ptr_gray_sync),
        .o_bin  (w_wr_ptr_bin)
    );

    // Forcing empty during reset also keeps read_enable low without a separate gate.
    assign w_empty           = !rst_n || (r_rd_ptr_gray == wr_ptr_gray_sync);
    assign w_fetch           = !w_empty && (!r_out_valid || out_ready);
    assign w_rd_ptr_bin_next = r_rd_ptr_bin + {{(PTR_W-1){1'b0}}, w_fetch};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr_bin  <= '0;
            r_rd_ptr_gray <= '0;
            r_fill_level  <= '0;
            r_out_valid   <= 1'b0;
        end else begin
            r_rd_ptr_bin  <= w_rd_ptr_bin_next;
            r_rd_ptr_gray <= w_rd_ptr_bin_next ^ (w_rd_ptr_bin_next >> 1);
            r_fill_level  <= w_wr_ptr_bin - w_rd_ptr_bin_next;
            r_out_valid   <= w_fetch || (r_out_valid && !out_ready);
        end
    end

    assign rd_ptr_gray = r_rd_ptr_gray;
    assign read_addr   = r_rd_ptr_bin[ADDR_W-1:0];
    assign read_enable = w_fetch;
    assign empty       = w_empty;
    assign fill_level  = r_fill_level;
    assign out_valid   = r_out_valid;

`ifdef SYNC_FIFO_RD_OVF_CHECK_EN
    logic [PTR_W-1:0] r_wr_gray_prev;
    logic             r_ovf_err;
    logic [PTR_W-1:0] w_wr_delta;
    logic [PTR_W-1:0] w_level_now;
    logic             w_multi_bit;

    // A legal synchronized Gray pointer moves by at most one bit per cycle.
    assign w_wr_delta  = wr_ptr_gray_sync ^ r_wr_gray_prev;
    assign w_multi_bit = (w_wr_delta & (w_wr_delta - 1'b1)) != '0;
    assign w_level_now = w_wr_ptr_bin - r_rd_ptr_bin;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_gray_prev <= '0;
            r_ovf_err      <= 1'b0;
        end else begin
            r_wr_gray_prev <= wr_ptr_gray_sync;
            if ((w_level_now > PTR_W'(DEPTH)) || w_multi_bit) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    assign ovf_err = r_ovf_err;
`endif

endmodule

// File: tb/tb_sync_fifo_rd_ctrl.sv
// tb/tb_sync_fifo_rd_ctrl.sv - randomized scoreboard bench for sync_fifo_rd_ctrl
module tb_sync_fifo_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  wr_ptr_gray_sync;
    logic [3:0]  rd_ptr_gray;
    logic [2:0]  read_addr;
    logic        read_enable;
    logic        empty;
    logic [3:0]  fill_level;
    logic        out_valid;
    logic        out_ready;
`ifdef SYNC_FIFO_RD_OVF_CHECK_EN
    logic        ovf_err;
`endif

    always #5 clk = ~clk;

    sync_fifo_rd_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_ptr_gray_sync (wr_ptr_gray_sync),
        .rd_ptr_gray      (rd_ptr_gray),
        .read_addr        (read_addr),
        .read_enable      (read_enable),
        .empty            (empty),
        .fill_level       (fill_level),
        .out_valid        (out_valid),
        .out_ready        (out_ready)
`ifdef SYNC_FIFO_RD_OVF_CHECK_EN
        ,
        .ovf_err          (ovf_err)
`endif
    );

    // Behavioural stand-in for the 8-entry register array.
    logic [31:0] mem [8];
    logic [31:0] r_data;
    always @(posedge clk) if (read_enable) r_data <= mem[read_addr];

    int          checks = 0;
    int          errors = 0;
    int          written = 0;
    int          fetched = 0;
    bit          exp_valid = 1'b0;
    int          exp_fill = 0;
    bit          mon_en = 1'b0;
    bit          saw_full = 1'b0;
    logic [31:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] gray_of(input int n);
        int b;
        b = n % 16;
        return 4'(b ^ (b >> 1));
    endfunction

    // Monitor: reference model counts words written and fetched.
    always @(negedge clk) begin
        bit exp_fetch;
        if (mon_en) begin
            exp_fetch = (written != fetched) && (!exp_valid || out_ready);
            chk("empty",       32'(empty),       32'(written == fetched));
            chk("read_enable", 32'(read_enable), 32'(exp_fetch));
            chk("read_addr",   32'(read_addr),   32'(fetched % 8));
            chk("rd_ptr_gray", 32'(rd_ptr_gray), 32'(gray_of(fetched)));
            chk("out_valid",   32'(out_valid),   32'(exp_valid));
            chk("fill_level",  32'(fill_level),  32'(exp_fill));
            if (out_valid && !out_ready) chk("hold_no_fetch", 32'(read_enable), 32'd0);
            if (exp_fill == 8 && fill_level == 4'd8) saw_full = 1'b1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_nonempty", 32'(sb.size()), 32'd1);
                else chk("data", r_data, sb.pop_front());
            end
            fetched   = fetched + (exp_fetch ? 1 : 0);
            exp_valid = exp_fetch || (exp_valid && !out_ready);
            exp_fill  = written - fetched;
        end
    end

    task automatic tick(input bit do_wr, input bit rdy);
        logic [31:0] d;
        @(posedge clk);
        #1;
        out_ready = rdy;
        if (do_wr && (written - fetched) < 8) begin
            d = $urandom;
            mem[written % 8] = d;
            sb.push_back(d);
            written++;
            wr_ptr_gray_sync = gray_of(written);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        wr_ptr_gray_sync = 4'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_empty",       32'(empty),       32'd1);
        chk("rst_read_enable", 32'(read_enable), 32'd0);
        chk("rst_out_valid",   32'(out_valid),   32'd0);
        chk("rst_rd_ptr_gray", 32'(rd_ptr_gray), 32'd0);
        chk("rst_fill_level",  32'(fill_level),  32'd0);
`ifdef SYNC_FIFO_RD_OVF_CHECK_EN
        chk("rst_ovf_err",     32'(ovf_err),     32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Three words, consumer always ready.
        repeat (3) tick(1'b1, 1'b1);
        repeat (6) tick(1'b0, 1'b1);
        @(negedge clk);
        chk("three_rd_ptr_gray", 32'(rd_ptr_gray), 32'h2);
        chk("three_empty",       32'(empty),       32'd1);

        // Consumer stalled with three words pending, then released.
        repeat (3) tick(1'b1, 1'b0);
        repeat (4) tick(1'b0, 1'b0);
        repeat (6) tick(1'b0, 1'b1);

        // Fill to full while stalled, then drain through the wrap.
        repeat (20) tick(1'b1, 1'b0);
        repeat (2) tick(1'b0, 1'b0);
        repeat (14) tick(1'b0, 1'b1);

        // Random stream with random back-pressure.
        repeat (300) tick($urandom_range(0, 99) < 60, 1'($urandom % 2));
        repeat (20) tick(1'b0, 1'b1);
        @(negedge clk);
        chk("sb_drained",   32'(sb.size()),          32'd0);
        chk("saw_full",     32'(saw_full),           32'd1);
        chk("all_fetched",  32'(written == fetched), 32'd1);
        chk("min_stream",   32'(written >= 20),      32'd1);

`ifdef SYNC_FIFO_RD_OVF_CHECK_EN
        chk("ovf_idle", 32'(ovf_err), 32'd0);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        wr_ptr_gray_sync = gray_of(written) ^ 4'b0011;
        @(negedge clk);
        @(negedge clk);
        chk("ovf_set", 32'(ovf_err), 32'd1);
        repeat (3) @(negedge clk);
        chk("ovf_sticky", 32'(ovf_err), 32'd1);
        rst_n = 1'b0;
        wr_ptr_gray_sync = 4'd0;
        @(negedge clk);
        chk("ovf_reset", 32'(ovf_err), 32'd0);
        chk("ovf_reset_empty", 32'(empty), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
